// File: rtl/risc_core_param.sv
// Parametrised multi-cycle RISC core: IR, 8-entry register file, shifter, ALU, N/V/Z flags.
// Optional feature: define RISC_SAT_ADD_EN to make ADD saturate on signed overflow.
module risc_core_param #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in,
  input  logic              load,
  input  logic              s,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w,
  output logic              ill
);

  localparam int unsigned Msb = DATA_W - 1;
  localparam logic [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StWait, StDecode, StWrImm, StGetA, StGetB, StExec, StWrite
  } state_e;

  state_e            r_state;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_rf [8];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_n, r_v, r_z;
  logic              r_wr;
  logic              r_ill;

  logic [2:0]        w_op;
  logic [1:0]        w_op2;
  logic [2:0]        w_rn, w_rd, w_rm;
  logic [1:0]        w_sh;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_b_raw;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_sum, w_diff, w_c;
  logic              w_add_v, w_cmp_v, w_v;
  logic              w_is_movi, w_is_mov, w_is_alu;

  assign w_op  = r_ir[15:13];
  assign w_op2 = r_ir[12:11];
  assign w_rn  = r_ir[10:8];
  assign w_rd  = r_ir[7:5];
  assign w_sh  = r_ir[4:3];
  assign w_rm  = r_ir[2:0];
  assign w_imm = DATA_W'($signed(r_ir[7:0]));

  assign w_is_movi = (w_op == 3'b110) && (w_op2 == 2'b10);
  assign w_is_mov  = (w_op == 3'b110) && (w_op2 == 2'b00);
  assign w_is_alu  = (w_op == 3'b101);

  assign w_b_raw = r_rf[w_rm];

  always_comb begin
    w_shifted = w_b_raw;
    unique case (w_sh)
      2'b00:   w_shifted = w_b_raw;
      2'b01:   w_shifted = {w_b_raw[Msb-1:0], 1'b0};
      2'b10:   w_shifted = {1'b0, w_b_raw[Msb:1]};
      default: w_shifted = {w_b_raw[Msb], w_b_raw[Msb:1]};
    endcase
  end

  assign w_sum   = r_a + r_b;
  assign w_diff  = r_a + ~r_b + DATA_W'(1);
  assign w_add_v = (r_a[Msb] == r_b[Msb]) && (w_sum[Msb] != r_a[Msb]);
  assign w_cmp_v = (r_a[Msb] != r_b[Msb]) && (w_diff[Msb] != r_a[Msb]);

  // MOV passes the shifted operand straight through as C.
  always_comb begin
    w_c = r_b;
    w_v = 1'b0;
    if (w_is_alu) begin
      unique case (w_op2)
        2'b00: begin
          w_c = w_sum;
          w_v = w_add_v;
`ifdef RISC_SAT_ADD_EN
          if (w_add_v) w_c = r_a[Msb] ? MinNeg : MaxPos;
`endif
        end
        2'b01: begin
          w_c = w_diff;
          w_v = w_cmp_v;
        end
        2'b10:   w_c = r_a & r_b;
        default: w_c = ~r_b;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StWait;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_wr    <= 1'b0;
      r_ill   <= 1'b0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else begin
      r_ill <= 1'b0;
      unique case (r_state)
        StWait: begin
          if (load) r_ir <= in;
          if (s) r_state <= StDecode;
        end
        StDecode: begin
          if (w_is_movi) begin
            r_state <= StWrImm;
          end else if (w_is_alu) begin
            r_state <= (w_op2 == 2'b11) ? StGetB : StGetA;
          end else if (w_is_mov) begin
            r_state <= StGetB;
          end else begin
            // Illegal: drain through WRITE with the write suppressed so w returns after two edges.
            r_ill   <= 1'b1;
            r_wr    <= 1'b0;
            r_state <= StWrite;
          end
        end
        StWrImm: begin
          r_rf[w_rn] <= w_imm;
          r_state    <= StWait;
        end
        StGetA: begin
          r_a     <= r_rf[w_rn];
          r_state <= StGetB;
        end
        StGetB: begin
          r_b     <= w_shifted;
          r_state <= StExec;
        end
        StExec: begin
          r_out <= w_c;
          if (w_is_alu) begin
            r_n <= w_c[Msb];
            r_z <= (w_c == '0);
            r_v <= w_v;
          end
          if (w_is_alu && (w_op2 == 2'b01)) begin
            r_state <= StWait;
          end else begin
            r_wr    <= 1'b1;
            r_state <= StWrite;
          end
        end
        StWrite: begin
          if (r_wr) r_rf[w_rd] <= r_out;
          r_wr    <= 1'b0;
          r_state <= StWait;
        end
        default: r_state <= StWait;
      endcase
    end
  end

  assign out = r_out;
  assign N   = r_n;
  assign V   = r_v;
  assign Z   = r_z;
  assign w   = (r_state == StWait);
  assign ill = r_ill;

endmodule

// File: tb/tb_risc_core_param.sv
// Bench for risc_core_param: a 16-bit and an 8-bit instance share one instruction stream and
// are checked every cycle against an arithmetic model of the instruction set.
module tb_risc_core_param;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        s;

  logic [15:0] out16;
  logic [7:0]  out8;
  logic        n16, v16, z16, w16, ill16;
  logic        n8, v8, z8, w8, ill8;

  risc_core_param #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
    .out(out16), .N(n16), .V(v16), .Z(z16), .w(w16), .ill(ill16)
  );

  risc_core_param #(.DATA_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
    .out(out8), .N(n8), .V(v8), .Z(z8), .w(w8), .ill(ill8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state, index 0 = 16-bit instance, 1 = 8-bit instance.
  logic [31:0] m_rf [2][8];
  logic [31:0] m_out [2];
  logic        m_n [2];
  logic        m_v [2];
  logic        m_z [2];
  logic [15:0] m_ir;
  logic        exp_w;
  logic        exp_ill;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_rf(input int k, input int i);
    if (k == 0) return 32'(u_dut16.r_rf[i]);
    return 32'(u_dut8.r_rf[i]);
  endfunction

  function automatic logic [31:0] dut_out(input int k);
    return (k == 0) ? 32'(out16) : 32'(out8);
  endfunction

  function automatic logic [31:0] dut_flags(input int k);
    return (k == 0) ? 32'({n16, v16, z16}) : 32'({n8, v8, z8});
  endfunction

  function automatic int width_of(input int k);
    return (k == 0) ? 16 : 8;
  endfunction

  function automatic int lat_of(input logic [15:0] ir);
    case ({ir[15:13], ir[12:11]})
      5'b110_10:            return 2;
      5'b110_00:            return 4;
      5'b101_01, 5'b101_11: return 4;
      5'b101_00, 5'b101_10: return 5;
      default:              return 2;
    endcase
  endfunction

  function automatic bit is_legal(input logic [15:0] ir);
    case ({ir[15:13], ir[12:11]})
      5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint to_signed(input longint x, input int wd);
    return (x >= (64'sd1 <<< (wd - 1))) ? x - (64'sd1 <<< wd) : x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_rf[k][i] = '0;
      m_out[k] = '0;
      m_n[k] = 1'b0;
      m_v[k] = 1'b0;
      m_z[k] = 1'b0;
    end
    m_ir = '0;
  endtask

  // Architectural effect of one instruction on model instance k.
  task automatic model_exec(input int k, input logic [15:0] ir);
    int     wd;
    longint mask, a, b, c, sr, maxp, minn, imm;
    logic [2:0] op, rn, rd, rm;
    logic [1:0] op2, sh;
    wd   = width_of(k);
    mask = (64'sd1 <<< wd) - 1;
    maxp = (64'sd1 <<< (wd - 1)) - 1;
    minn = -(64'sd1 <<< (wd - 1));
    op = ir[15:13]; op2 = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    a = longint'(m_rf[k][rn]);
    b = longint'(m_rf[k][rm]);
    case (sh)
      2'b01:   b = (b * 2) & mask;
      2'b10:   b = b / 2;
      2'b11:   b = (b / 2) + (b & (64'sd1 <<< (wd - 1)));
      default: b = b;
    endcase
    if (op == 3'b110 && op2 == 2'b10) begin
      imm = longint'(ir[7:0]);
      if (imm >= 128) imm = imm - 256;
      m_rf[k][rn] = 32'(imm & mask);
    end else if (op == 3'b110 && op2 == 2'b00) begin
      m_out[k] = 32'(b);
      m_rf[k][rd] = 32'(b);
    end else if (op == 3'b101) begin
      m_v[k] = 1'b0;
      case (op2)
        2'b00: begin
          sr = to_signed(a, wd) + to_signed(b, wd);
          m_v[k] = (sr > maxp) || (sr < minn);
          c = (a + b) & mask;
`ifdef RISC_SAT_ADD_EN
          if (sr > maxp) c = maxp;
          else if (sr < minn) c = minn & mask;
`endif
        end
        2'b01: begin
          sr = to_signed(a, wd) - to_signed(b, wd);
          m_v[k] = (sr > maxp) || (sr < minn);
          c = (a - b) & mask;
        end
        2'b10:   c = a & b;
        default: c = (~b) & mask;
      endcase
      m_n[k] = ((c >> (wd - 1)) & 1) != 0;
      m_z[k] = (c == 0);
      m_out[k] = 32'(c);
      if (op2 != 2'b01) m_rf[k][rd] = 32'(c);
    end
  endtask

  // Per-cycle compare: handshake every cycle, architectural state whenever the core is idle.
  always @(negedge clk) begin
    check("w16", 32'(w16), 32'(exp_w));
    check("w8", 32'(w8), 32'(exp_w));
    check("ill16", 32'(ill16), 32'(exp_ill));
    check("ill8", 32'(ill8), 32'(exp_ill));
    if (exp_w) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("out[%0d]", width_of(k)), dut_out(k), m_out[k]);
        check($sformatf("nvz[%0d]", width_of(k)), dut_flags(k),
              32'({m_n[k], m_v[k], m_z[k]}));
        for (int i = 0; i < 8; i++)
          check($sformatf("R%0d[%0d]", i, width_of(k)), dut_rf(k, i), m_rf[k][i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: load then s next cycle; mode 1: load and s together; mode 2: s only (re-run IR).
  task automatic run(input logic [15:0] instr, input int mode, input bit disturb);
    logic [15:0] ir;
    int lat;
    if (mode == 0) begin
      in = instr; load = 1'b1;
      step();
      load = 1'b0;
      m_ir = instr;
    end else if (mode == 1) begin
      in = instr; load = 1'b1;
      m_ir = instr;
    end
    s = 1'b1;
    step();
    s = 1'b0; load = 1'b0;
    exp_w = 1'b0;
    ir  = m_ir;
    lat = lat_of(ir);
    for (int k = 1; k <= lat; k++) begin
      if (disturb && k == 1) begin
        load = 1'b1; in = 16'hD0FF;
      end else if ($urandom_range(3) == 0) begin
        load = 1'b1; in = 16'($urandom);
      end
      step();
      load = 1'b0;
      exp_ill = !is_legal(ir) && (k == 1);
      if (k == lat) begin
        exp_w = 1'b1;
        model_exec(0, ir);
        model_exec(1, ir);
      end
    end
  endtask

  task automatic run_reset_in_exec(input logic [15:0] instr);
    in = instr; load = 1'b1;
    step();
    load = 1'b0;
    s = 1'b1;
    step();
    s = 1'b0;
    exp_w = 1'b0;
    step();
    step();
    step();
    reset = 1'b0;
    #1;
    model_reset();
    exp_w = 1'b1;
    exp_ill = 1'b0;
    check("rst_w16", 32'(w16), 32'd1);
    check("rst_w8", 32'(w8), 32'd1);
    check("rst_out16", 32'(out16), 32'd0);
    check("rst_out8", 32'(out8), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rst_R%0d_16", i), dut_rf(0, i), 32'd0);
      check($sformatf("rst_R%0d_8", i), dut_rf(1, i), 32'd0);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [2:0] op;
    case ($urandom_range(9))
      0, 1:       return {3'b110, 2'b10, 11'($urandom)};
      2:          return {3'b110, 2'b00, 11'($urandom)};
      3, 4, 5, 6: return {3'b101, 13'($urandom)};
      7: begin
        op = 3'($urandom_range(4));
        if (op == 3'd4) op = 3'd7;
        return {op, 13'($urandom)};
      end
      default:    return 16'($urandom);
    endcase
  endfunction

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b0;
    in = '0;
    load = 1'b0;
    s = 1'b0;
    exp_w = 1'b1;
    exp_ill = 1'b0;
    model_reset();
    step();
    step();
    reset = 1'b1;
    step();

    // MOVI R0,#2
    run(16'hD002, 0, 1'b0);
    check("t1_R0_16", dut_rf(0, 0), 32'h0002);
    check("t1_R0_8", dut_rf(1, 0), 32'h02);
    check("t1_flags16", 32'({n16, v16, z16}), 32'd0);

    // MOVI R1,#-128 ; ADD R2,R0,R1 LSL1
    run(16'hD180, 0, 1'b0);
    check("t2_R1_16", dut_rf(0, 1), 32'hFF80);
    check("t2_R1_8", dut_rf(1, 1), 32'h80);
    run(16'hA049, 0, 1'b0);
    check("t2_R2_16", dut_rf(0, 2), 32'hFF02);
    check("t2_nvz16", 32'({n16, v16, z16}), 32'b100);

    // CMP R2,R2
    run(16'hAA02, 0, 1'b0);
    check("t3_nvz16", 32'({n16, v16, z16}), 32'b001);
    check("t3_R2_16", dut_rf(0, 2), 32'hFF02);

    // MOVI R3,#0x7F ; ADD R5,R3,R3
    run(16'hD37F, 0, 1'b0);
    run(16'hA3A3, 0, 1'b0);
    check("t4_R5_16", dut_rf(0, 5), 32'h00FE);
    check("t4_v16", 32'(v16), 32'd0);
    check("t4_v8", 32'(v8), 32'd1);
`ifdef RISC_SAT_ADD_EN
    check("t4_R5_8", dut_rf(1, 5), 32'h7F);
    check("t4_n8", 32'(n8), 32'd0);
`else
    check("t4_R5_8", dut_rf(1, 5), 32'hFE);
    check("t4_n8", 32'(n8), 32'd1);
`endif

    // IR load attempted during DECODE must be ignored.
    run(16'hA049, 0, 1'b1);
    check("t5_R2_16", dut_rf(0, 2), 32'hFF02);
    check("t5_R7_16", dut_rf(0, 7), 32'h0000);
    run_reset_in_exec(16'hA049);

    // IR cleared by reset decodes as illegal.
    run(16'h0000, 2, 1'b0);
    run(16'hD2F0, 1, 1'b0);
    check("t6_R2_16", dut_rf(0, 2), 32'hFFF0);
    run(16'hE000, 0, 1'b0);
    run(16'hB800, 1, 1'b0);

    for (int t = 0; t < 400; t++)
      run(rand_instr(), $urandom_range(2), 1'($urandom_range(1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
